// File: rtl/aer_core_merger.sv
// aer_core_merger: round-robin merge of per-core AER outputs into one
// feature-map-addressed AER stream, 4-phase REQ/ACK on both sides.
module aer_core_merger #(
  parameter int FM_C          = 3,
  parameter int FM_W          = 8,
  parameter int FM_H          = 8,
  parameter int CORE_W        = 4,
  parameter int CORE_H        = 4,
  parameter int IN_AER_WIDTH  = 2 + $clog2(FM_C) + $clog2(FM_H / CORE_H) + $clog2(FM_W / CORE_W),
  parameter int OUT_AER_WIDTH = 2 + $clog2(FM_C) + $clog2(FM_H) + $clog2(FM_W)
) (
  input  logic                                            clk,
  input  logic                                            rst,
  input  logic [CORE_W*CORE_H-1:0]                        CORE_AEROUT_REQ,
  input  logic [CORE_W*CORE_H-1:0][IN_AER_WIDTH-1:0]      CORE_AEROUT_EVENT,
  output logic [CORE_W*CORE_H-1:0]                        CORE_AEROUT_ACK,
  output logic                                            MRG_AEROUT_REQ,
  output logic [OUT_AER_WIDTH-1:0]                        MRG_AEROUT_EVENT,
  input  logic                                            MRG_AEROUT_ACK
);

  localparam int N        = CORE_W * CORE_H;
  localparam int TILE_W   = FM_W / CORE_W;
  localparam int TILE_H   = FM_H / CORE_H;
  localparam int C_BITS   = $clog2(FM_C);
  localparam int LY_BITS  = $clog2(TILE_H);
  localparam int LX_BITS  = $clog2(TILE_W);
  localparam int Y_BITS   = $clog2(FM_H);
  localparam int X_BITS   = $clog2(FM_W);
  localparam int IDX_BITS = (N > 1) ? $clog2(N) : 1;
  localparam int PAY_BITS = IN_AER_WIDTH - 2;
  localparam int PASS_W   = OUT_AER_WIDTH - 2;

  typedef enum logic [1:0] {
    IDLE,
    IN_REL,
    OUT_ACK,
    OUT_REL
  } state_t;

  state_t                     state_q, state_d;
  logic [IDX_BITS-1:0]        ptr_q, ptr_d;
  logic [IDX_BITS-1:0]        grant_q, grant_d;
  logic [OUT_AER_WIDTH-1:0]   event_q, event_d;
  logic [N-1:0]               ack_q, ack_d;
  logic                       mrg_req_q, mrg_req_d;
  logic                       found;
  logic [IDX_BITS-1:0]        sel_idx;

  // Translate a core-local event into the global feature-map address space;
  // non-neuron events keep their type and carry the raw payload unchanged.
  function automatic logic [OUT_AER_WIDTH-1:0] remap(
    input logic [IDX_BITS-1:0]     idx,
    input logic [IN_AER_WIDTH-1:0] ev
  );
    logic [1:0]         ev_type;
    logic [C_BITS-1:0]  c;
    logic [LY_BITS-1:0] ly;
    logic [LX_BITS-1:0] lx;
    logic [X_BITS-1:0]  x;
    logic [Y_BITS-1:0]  y;
    ev_type = ev[IN_AER_WIDTH-1 -: 2];
    c       = ev[LY_BITS + LX_BITS +: C_BITS];
    ly      = ev[LX_BITS +: LY_BITS];
    lx      = ev[0 +: LX_BITS];
    x = X_BITS'((int'(idx) % CORE_W) * TILE_W) + X_BITS'(lx);
    y = Y_BITS'((int'(idx) / CORE_W) * TILE_H) + Y_BITS'(ly);
    if (ev_type == 2'b00) begin
      remap = {ev_type, c, y, x};
    end else begin
      remap = {ev_type, PASS_W'(ev[PAY_BITS-1:0])};
    end
  endfunction

  // Pick the first requesting core at or after the round-robin pointer, wrapping.
  always_comb begin
    int cand;
    found   = 1'b0;
    sel_idx = '0;
    cand    = 0;
    for (int k = 0; k < N; k++) begin
      cand = (int'(ptr_q) + k) % N;
      if (!found && CORE_AEROUT_REQ[IDX_BITS'(cand)]) begin
        found   = 1'b1;
        sel_idx = IDX_BITS'(cand);
      end
    end
  end

  // Handshake sequencing: grant, wait for core release, present merged event, wait downstream.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    grant_d   = grant_q;
    event_d   = event_q;
    ack_d     = ack_q;
    mrg_req_d = mrg_req_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d = sel_idx;
          event_d = remap(sel_idx, CORE_AEROUT_EVENT[sel_idx]);
          ack_d   = N'(1) << sel_idx;
          state_d = IN_REL;
        end
      end
      IN_REL: begin
        if (!CORE_AEROUT_REQ[grant_q]) begin
          ack_d     = '0;
          mrg_req_d = 1'b1;
          state_d   = OUT_ACK;
        end
      end
      OUT_ACK: begin
        if (MRG_AEROUT_ACK) begin
          mrg_req_d = 1'b0;
          state_d   = OUT_REL;
        end
      end
      OUT_REL: begin
        if (!MRG_AEROUT_ACK) begin
          ptr_d   = (grant_q == IDX_BITS'(N - 1)) ? '0 : grant_q + 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // All state and outputs are registered; reset clears everything on the next edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      grant_q   <= '0;
      event_q   <= '0;
      ack_q     <= '0;
      mrg_req_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      grant_q   <= grant_d;
      event_q   <= event_d;
      ack_q     <= ack_d;
      mrg_req_q <= mrg_req_d;
    end
  end

  assign CORE_AEROUT_ACK  = ack_q;
  assign MRG_AEROUT_REQ   = mrg_req_q;
  assign MRG_AEROUT_EVENT = event_q;

endmodule
